// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage in front of an external combinational ALU. Requests are
// buffered in a small FIFO. The FIFO head is presented to the ALU, and the
// ALU answer is captured into a single result register together with the
// request's sequence tag and an illegal-opcode flag.
//
// Opcodes: 000 add, 001 sub, 010 unsigned greater-than, 011 unsigned
// less-than. 100-111 are illegal: they still produce a result (value 0,
// out_err=1), so the tag sequence seen downstream has no gaps.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        request handshake (in_ready = FIFO not full)
//   in_a, in_b, in_opcode    request operands and opcode
//   alu_a, alu_b, alu_opcode FIFO head to the ALU (all zero when empty)
//   alu_result               combinational ALU answer for the head
//   out_valid/out_ready      result handshake
//   out_result, out_tag,     registered result, sequence tag and
//   out_err                  illegal-opcode flag
//   count                    FIFO occupancy (excludes the result register)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_opcode,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_opcode,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [7:0]             out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_issue_stage: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [7:0]       tag;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t           fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       in_seq_q, in_seq_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [7:0]       out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic   fifo_empty;
  logic   push;
  logic   pop;
  entry_t head;
  entry_t new_entry;
  logic   head_illegal;

  assign fifo_empty = (count_q == '0);
  // No bypass: a full FIFO refuses a request even if a pop happens this cycle.
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  // The head moves into the result register whenever that register is empty
  // or is being drained in the same cycle.
  assign pop        = !fifo_empty && (!out_valid_q || out_ready);

  assign new_entry.a   = in_a;
  assign new_entry.b   = in_b;
  assign new_entry.op  = in_opcode;
  assign new_entry.tag = in_seq_q;

  // Head is read straight out of registered storage; the empty gate keeps
  // stale entries from reaching the ALU.
  always_comb begin
    head = '0;
    if (!fifo_empty) begin
      head = fifo_q[rd_ptr_q];
    end
  end

  assign alu_a        = head.a;
  assign alu_b        = head.b;
  assign alu_opcode   = head.op;
  assign head_illegal = head.op[2];

  // ---------------------------------------------------------------------------
  // FIFO storage (data only, no reset needed: occupancy gates every read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_q[wr_ptr_q] <= new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    in_seq_d = in_seq_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      in_seq_d = in_seq_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;

    if (pop) begin
      out_valid_d  = 1'b1;
      out_result_d = head_illegal ? '0 : alu_result;
      out_tag_d    = head.tag;
      out_err_d    = head_illegal;
    end else if (out_valid_q && out_ready) begin
      // Consumed with nothing to replace it: drop valid, keep the payload.
      out_valid_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_seq_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_seq_q     <= in_seq_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
    end
  end

  assign count      = count_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Drives alu_issue_stage with a behavioural ALU attached to alu_a/alu_b/
// alu_opcode. Every accepted request pushes its expected result onto a
// scoreboard queue; every consumed result pops and compares. Scenario tasks
// add their own inline checks on occupancy, latency and handshakes.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [7:0]       out_tag;
  logic             out_err;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .count      (count)
  );

  // Downstream ALU. Illegal opcodes return garbage so that the stage's
  // forcing of their result to zero is observable.
  always_comb begin
    case (alu_opcode)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = (alu_a > alu_b) ? 32'd1 : 32'd0;
      3'd3:    alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [7:0]       tag;
    logic             err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] tb_seq;
  int         checks;
  int         errors;
  int         n_results;

  function automatic exp_t expect_of(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                     logic [2:0] op, logic [7:0] tag);
    exp_t e;
    e.tag = tag;
    e.err = op[2];
    case (op)
      3'd0:    e.res = a + b;
      3'd1:    e.res = a - b;
      3'd2:    e.res = (a > b) ? 32'd1 : 32'd0;
      3'd3:    e.res = (a < b) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst      = 1'b0;
  endtask

  // Runs until the scoreboard and result register are empty (bounded).
  task automatic drain(output bit ok);
    int w;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 600) begin
      tick();
      w++;
    end
    ok = (sb.size() == 0) && !out_valid;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;          // a request during reset must be ignored
    in_a      = 32'd7;
    in_b      = 32'd7;
    in_opcode = 3'd0;
    out_ready = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (count !== '0)        begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_result !== '0)   begin errors++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
    checks++; if (out_tag !== 8'd0)    begin errors++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
    checks++; if (out_err !== 1'b0)    begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    checks++; if ({alu_a, alu_b, alu_opcode} !== '0)
      begin errors++; $display("FAIL reset_alu_head: got a=%h b=%h op=%0d expected all 0", alu_a, alu_b, alu_opcode); end
    tick();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_no_leak: got out_valid=%b expected 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    bit ok;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd5;
    in_b      = 32'd3;
    in_opcode = 3'd0;
    tick();                     // accepted
    in_valid = 1'b0;
    checks++; if (count !== CW'(1))   begin errors++; $display("FAIL add_count_k: got %0d expected 1", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b expected 0", out_valid); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3)
      begin errors++; $display("FAIL add_head: got a=%0d b=%0d expected a=5 b=3", alu_a, alu_b); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_tag !== 8'd0 || out_err !== 1'b0)
      begin errors++; $display("FAIL add_result: got v=%b r=%0d t=%0d e=%b expected v=1 r=8 t=0 e=0", out_valid, out_result, out_tag, out_err); end
    checks++; if (count !== '0)       begin errors++; $display("FAIL add_count_k1: got %0d expected 0", count); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd8)
      begin errors++; $display("FAIL add_consumed: got v=%b r=%0d expected v=0 r=8 held", out_valid, out_result); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_drain: got pending=%0d expected 0", sb.size()); end
    $display("test_single_add done");
  endtask

  task automatic test_backpressure();
    bit ok;
    int w;
    int base;
    do_reset();
    base      = n_results;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid  = 1'b1;
      in_a      = 32'(10 + i);
      in_b      = 32'd3;
      in_opcode = 3'd1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 1", i, in_ready); end
      tick();
    end
    checks++; if (count !== CW'(DEPTH) || in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_full: got count=%0d ready=%b expected count=%0d ready=0", count, in_ready, DEPTH); end
    // Sixth request waits while the consumer stalls.
    in_valid = 1'b1;
    in_a     = 32'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (in_ready !== 1'b0 || count !== CW'(DEPTH) || out_valid !== 1'b1 || out_result !== 32'd7 || out_tag !== 8'd0)
        begin errors++; $display("FAIL bp_hold_%0d: got ready=%b count=%0d v=%b r=%0d t=%0d expected 0 %0d 1 7 0", i, in_ready, count, out_valid, out_result, out_tag, DEPTH); end
    end
    out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    checks++; if (!in_ready) begin errors++; $display("FAIL bp_release: got in_ready=0 expected 1 within 10 cycles"); end
    tick();
    in_valid = 1'b0;
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got pending=%0d expected 0", sb.size()); end
    checks++; if (n_results - base !== DEPTH + 2)
      begin errors++; $display("FAIL bp_result_count: got %0d expected %0d", n_results - base, DEPTH + 2); end
    $display("test_backpressure done");
  endtask

  task automatic test_illegal();
    bit ok;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd1;
    in_b      = 32'd1;
    in_opcode = 3'b101;
    tick();
    in_a      = 32'd2;
    in_b      = 32'd9;
    in_opcode = 3'b011;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_result !== '0)
      begin errors++; $display("FAIL illegal_result: got v=%b e=%b r=%h expected v=1 e=1 r=0", out_valid, out_err, out_result); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_result !== 32'd1)
      begin errors++; $display("FAIL lt_after_illegal: got v=%b e=%b r=%h expected v=1 e=0 r=1", out_valid, out_err, out_result); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_drain: got pending=%0d expected 0", sb.size()); end
    $display("test_illegal done");
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_a      = 32'(i + 1);
      in_b      = 32'd1;
      in_opcode = 3'd0;
      tick();
    end
    checks++; if (count !== CW'(2) || out_valid !== 1'b1)
      begin errors++; $display("FAIL sim_setup: got count=%0d v=%b expected 2 1", count, out_valid); end
    in_a      = 32'hFFFF_FFFF;
    in_b      = 32'd1;
    in_opcode = 3'd2;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== CW'(2))
      begin errors++; $display("FAIL sim_count: got %0d expected 2", count); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_drain: got pending=%0d expected 0", sb.size()); end
    $display("test_simul_push_pop done");
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         base;
    logic [7:0] exp_tag;
    do_reset();
    base      = n_results;
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid  = 1'b1;
      in_a      = $urandom;
      in_b      = $urandom;
      in_opcode = 3'($urandom_range(0, 7));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready); end
      tick();
      if (i >= 1) begin
        exp_tag = 8'(i - 1);
        checks++; if (out_valid !== 1'b1 || out_tag !== exp_tag)
          begin errors++; $display("FAIL b2b_stream_%0d: got v=%b t=%0d expected v=1 t=%0d", i, out_valid, out_tag, exp_tag); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_tag !== 8'd0)
      begin errors++; $display("FAIL b2b_wrap: got v=%b t=%0d expected v=1 t=0", out_valid, out_tag); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got pending=%0d expected 0", sb.size()); end
    checks++; if (n_results - base !== 257)
      begin errors++; $display("FAIL b2b_result_count: got %0d expected 257", n_results - base); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_a      = 32'(100 + i);
      in_b      = 32'd1;
      in_opcode = 3'd0;
      tick();
    end
    checks++; if (count !== CW'(3) || out_valid !== 1'b1 || out_result !== 32'd101)
      begin errors++; $display("FAIL mid_setup: got count=%0d v=%b r=%0d expected 3 1 101", count, out_valid, out_result); end
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd9;
    out_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++; if (count !== '0 || out_valid !== 1'b0 || out_result !== '0 || out_tag !== 8'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset: got count=%0d v=%b r=%0d t=%0d rdy=%b expected 0 0 0 0 1", count, out_valid, out_result, out_tag, in_ready); end
    in_valid  = 1'b1;
    in_a      = 32'd20;
    in_b      = 32'd22;
    in_opcode = 3'd0;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_tag !== 8'd0 || out_result !== 32'd42)
      begin errors++; $display("FAIL mid_first_after: got v=%b t=%0d r=%0d expected 1 0 42", out_valid, out_tag, out_result); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_drain: got pending=%0d expected 0", sb.size()); end
    $display("test_reset_mid done");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    checks    = 0;
    errors    = 0;
    n_results = 0;
    tb_seq    = 8'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_opcode = '0;
    out_ready = 1'b0;

    // Scoreboard monitor: samples on the falling edge, where inputs and
    // state are stable for the coming rising edge.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          sb.delete();
          tb_seq = 8'd0;
        end else begin
          if (out_valid && out_ready) begin
            n_results++;
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL sb_underflow: got result tag=%0d expected none", out_tag);
            end else begin
              mon_e = sb.pop_front();
              if (out_result !== mon_e.res || out_tag !== mon_e.tag || out_err !== mon_e.err) begin
                errors++;
                $display("FAIL sb_result: got r=%h t=%0d e=%b expected r=%h t=%0d e=%b",
                         out_result, out_tag, out_err, mon_e.res, mon_e.tag, mon_e.err);
              end else begin
                $display("result tag=%0d r=%h err=%b ok", out_tag, out_result, out_err);
              end
            end
          end
          if (in_valid && in_ready) begin
            sb.push_back(expect_of(in_a, in_b, in_opcode, tb_seq));
            tb_seq = tb_seq + 8'd1;
          end
        end
      end
    join_none

    test_reset();
    test_single_add();
    test_backpressure();
    test_illegal();
    test_simul_push_pop();
    test_back_to_back();
    test_reset_mid();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
